// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: assembles WIDTH serial bits into a word and holds it
// in a one-entry valid/ready output buffer. Define SER_RX_PARITY_EN to add an even-parity bit per frame.
module serial_word_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             shift_right,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SER_RX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
`ifdef SER_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] done_word;
  logic             word_done;
  logic             can_load;
  logic             load;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      sh_q         <= '0;
      dir_q        <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SER_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sh_q         <= sh_d;
      dir_q        <= dir_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef SER_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic; frame_clr always returns to IDLE.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (frame_clr) begin
      state_d = ST_IDLE;
    end else if (ser_valid) begin
      case (state_q)
        ST_IDLE: state_d = ST_DATA;
        ST_DATA: begin
          if (count_q == LAST_CNT) begin
`ifdef SER_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef SER_RX_PARITY_EN
        ST_PARITY: state_d = ST_IDLE;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bit order is latched from the first bit; later shift_right changes are ignored.
  assign shifted    = dir_q ? {ser_in, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], ser_in};
  assign first_word = shift_right ? {ser_in, {(WIDTH-1){1'b0}}}
                                  : {{(WIDTH-1){1'b0}}, ser_in};

`ifdef SER_RX_PARITY_EN
  assign word_done = ser_valid && !frame_clr && (state_q == ST_PARITY);
  assign done_word = sh_q;
`else
  assign word_done = ser_valid && !frame_clr && (state_q == ST_DATA) && (count_q == LAST_CNT);
  assign done_word = shifted;
`endif

  // The buffer can take a new word when empty or when it is being drained this same cycle.
  assign can_load = !data_valid_q || data_ready;
  assign load     = word_done && can_load;

  // Output / datapath logic
  always_comb begin
    count_d      = count_q;
    sh_d         = sh_q;
    dir_d        = dir_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = word_done && !can_load;
`ifdef SER_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    if (frame_clr) begin
      count_d = '0;
      sh_d    = '0;
    end else if (ser_valid) begin
      case (state_q)
        ST_IDLE: begin
          sh_d    = first_word;
          dir_d   = shift_right;
          count_d = CW'(1);
        end
        ST_DATA: begin
          sh_d = shifted;
          if (count_q == LAST_CNT) begin
`ifdef SER_RX_PARITY_EN
            count_d = CW'(WIDTH);
`else
            count_d = '0;
`endif
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: count_d = '0;
      endcase
    end

    if (load) begin
      data_d       = done_word;
      data_valid_d = 1'b1;
`ifdef SER_RX_PARITY_EN
      parity_err_d = (^sh_q) != ser_in;
`endif
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign data_out   = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
`ifdef SER_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver. It collects a stream of single-bit samples, qualified by `ser_valid`, into a WIDTH-bit word. It then presents the word on a one-entry output buffer with a valid/ready handshake. It sits on the receive side of the team's bit-serial links, opposite the parallel-load rotate/shift registers that drive those links. Bit order is selectable per frame.

## Interface
- `WIDTH`, default 4: data bits per frame (≥2).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `ser_in`  in  1  serial data bit.
- `ser_valid`  in  1  `ser_in` is a valid bit this cycle; gaps allowed between bits.
- `shift_right`  in  1  bit order; sampled only on a frame's first bit.
  - 1: LSB-first; bits enter at the MSB and shift toward the LSB.
  - 0: MSB-first; bits enter at the LSB and shift toward the MSB.
- `frame_clr`  in  1  discard any partial frame; no effect on the output buffer.
- `data_out`  out  WIDTH  received word; held stable while `data_valid`=1.
- `data_valid`  out  1  output buffer holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word; transfer occurs when `data_valid & data_ready`.
- `busy`  out  1  a frame is partially received (state ≠ IDLE).
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `parity_err`  out  1  parity mismatch for the word in the buffer; valid while `data_valid`=1.

## Operation
- FSM states:
  - IDLE: `ser_valid` stores bit 1, latches `shift_right`, sets count=1, and moves to DATA.
  - DATA: each `ser_valid` shifts one bit in and increments count.
    - When the WIDTH-th bit is sampled, the word completes and the FSM returns to IDLE (or goes to PARITY if enabled).
  - PARITY: present only with `SER_RX_PARITY_EN`. The next `ser_valid` bit is the even-parity bit; the word then completes and the FSM returns to IDLE.
- Shift rules, with `sh` as the shift register:
  - MSB-first: `sh <= {sh[WIDTH-2:0], ser_in}`.
  - LSB-first: `sh <= {ser_in, sh[WIDTH-1:1]}`.
- Completing the word (on the same edge as the final bit):
  - If the buffer is empty, or is being consumed this cycle (`data_valid & data_ready`), the word loads into `data_out` and `data_valid` stays or becomes 1.
  - Otherwise the new word is dropped, the buffered word is kept, and `overrun` pulses for the next cycle.
- Back-to-back frames: a bit arriving in IDLE on the cycle after completion starts a new frame; no dead cycle.
- `frame_clr`:
  - Forces IDLE, clears count and `sh`, and discards a bit presented in the same cycle.
  - Has priority over completion: a final bit coinciding with `frame_clr` is discarded, with no load and no overrun.
- `reset` clears everything and has priority over `frame_clr` and all other inputs.
  - Reset mid-frame discards the partial word.
  - Reset with `data_valid`=1 drops the buffered word.
- Widths: the counter is `$clog2(WIDTH+1)` bits; the count never wraps beyond WIDTH.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0, FSM=IDLE, count=0.
- All outputs are registered; there are no combinational paths from input to output.
- Latency: `data_valid` and the new `data_out` are visible one cycle after the edge that samples the final bit (the final data bit, or the parity bit).
- `busy` is high from the cycle after the first bit until the cycle after completion.
- Simultaneous consume and complete: there is no bubble; `data_valid` stays 1 and `data_out` updates.
- Consume with no completion: `data_valid` drops the next cycle.
- Maximum throughput: one word per WIDTH cycles, or WIDTH+1 with parity.

## Configuration
- `SER_RX_PARITY_EN` defined:
  - The PARITY state is present, and each frame is WIDTH+1 bits.
  - `parity_err` = (XOR of the data bits) ≠ parity bit; it loads together with `data_out`.
  - A dropped word does not alter `parity_err`.
- `SER_RX_PARITY_EN` undefined:
  - There is no PARITY state, and frames are WIDTH bits.
  - `parity_err` is tied to 0.

## Test plan
- Reset with WIDTH=4; `shift_right`=0; bits 1,0,1,1 on consecutive cycles; `data_ready`=1 → `data_out`=4'b1011 and `data_valid` high for 1 cycle, one cycle after the 4th bit; `busy` then low.
- `shift_right`=1; bits 1,0,1,1, with 2-cycle gaps between bits → `data_out`=4'b1101. Toggling `shift_right` mid-frame has no effect.
- `data_ready`=0; send two frames 4'hA then 4'h5 (MSB-first) → `data_out` stays 4'hA, `overrun` pulses once. Raising `data_ready` → `data_valid` drops next cycle.
- `data_ready`=1 held and two frames back-to-back (8 consecutive `ser_valid` cycles, 4'h3 then 4'hC) → `data_out` shows 4'h3 then 4'hC four cycles later, with no `overrun`.
- Mid-frame checks:
  - 2 bits sent, then `frame_clr` → `busy`=0; next frame 4'h6 received correctly.
  - `reset` pulsed after 3 bits, with a word buffered → all outputs 0.
- Parity, with `SER_RX_PARITY_EN`, MSB-first:
  - bits 1,1,0,1 + parity 1 → 4'hD, `parity_err`=0.
  - parity 0 instead → `parity_err`=1.
  - Without the macro, a 5th bit starts a new frame.
